id_ex_pipe: RTL and testbench

ID/EX pipeline register of the pipelined MIPS core. It latches the control word produced by the instruction decoder together with ID-stage operands and register specifiers, and presents them to the EX stage one cycle later. It also performs load-use hazard detection: on a hazard it raises a stall request to the PC and IF/ID register and injects a bubble. It turns a branch flush into a bubble and keeps saturating stall and flush event counters.

---
 rtl/id_ex_pipe.sv | 139 +++++++++++++
 tb/tb_id_ex_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the pipelined MIPS core: latches the decoder control
// word and ID operands, detects load-use hazards and converts flushes/stalls into bubbles.
module id_ex_pipe (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_regwrite_i,
    input  logic        id_alusrc_i,
    input  logic        id_regdst_i,
    input  logic        id_branch_i,
    input  logic        id_memread_i,
    input  logic        id_memwrite_i,
    input  logic        id_memtoreg_i,
    input  logic [2:0]  id_aluop_i,
    input  logic [5:0]  id_op_i,
    input  logic [5:0]  id_funct_i,
    input  logic [31:0] id_pc4_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic        flush_i,
    output logic        ex_regwrite_o,
    output logic        ex_alusrc_o,
    output logic        ex_regdst_o,
    output logic        ex_branch_o,
    output logic        ex_memread_o,
    output logic        ex_memwrite_o,
    output logic        ex_memtoreg_o,
    output logic [2:0]  ex_aluop_o,
    output logic [5:0]  ex_op_o,
    output logic [5:0]  ex_funct_o,
    output logic [31:0] ex_pc4_o,
    output logic [31:0] ex_rs_data_o,
    output logic [31:0] ex_rt_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rs_o,
    output logic [4:0]  ex_rt_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_valid_o,
    output logic        stall_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    // Control word layout: {regwrite, alusrc, regdst, branch, memread, memwrite, memtoreg, aluop[2:0]}
    logic [9:0]  ctrl_q, ctrl_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [5:0]  op_q, funct_q;
    logic [31:0] pc4_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic        hz_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hz_s = valid_q & ctrl_q[5] & (rt_q != 5'd0) &
                  ((rt_q == id_rs_i) | (rt_q == id_rt_i));
    assign stall_o = hz_s & ~flush_i;

    // Next-state selection: flush, then load-use stall, then normal load
    always_comb begin
        ctrl_d      = {id_regwrite_i, id_alusrc_i, id_regdst_i, id_branch_i,
                       id_memread_i, id_memwrite_i, id_memtoreg_i, id_aluop_i};
        valid_d     = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_i) begin
            ctrl_d      = 10'd0;
            valid_d     = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (hz_s) begin
            ctrl_d      = 10'd0;
            valid_d     = 1'b0;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            valid_d     = 1'b1;
        end
    end

    // Pipeline and counter registers; data fields load even on a bubble (don't-care)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q      <= 10'd0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            op_q        <= 6'd0;
            funct_q     <= 6'd0;
            pc4_q       <= 32'd0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm_q       <= 32'd0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            op_q        <= id_op_i;
            funct_q     <= id_funct_i;
            pc4_q       <= id_pc4_i;
            rs_data_q   <= id_rs_data_i;
            rt_data_q   <= id_rt_data_i;
            imm_q       <= id_imm_i;
            rs_q        <= id_rs_i;
            rt_q        <= id_rt_i;
            rd_q        <= id_rd_i;
        end
    end

    assign ex_regwrite_o = ctrl_q[9];
    assign ex_alusrc_o   = ctrl_q[8];
    assign ex_regdst_o   = ctrl_q[7];
    assign ex_branch_o   = ctrl_q[6];
    assign ex_memread_o  = ctrl_q[5];
    assign ex_memwrite_o = ctrl_q[4];
    assign ex_memtoreg_o = ctrl_q[3];
    assign ex_aluop_o    = ctrl_q[2:0];
    assign ex_op_o       = op_q;
    assign ex_funct_o    = funct_q;
    assign ex_pc4_o      = pc4_q;
    assign ex_rs_data_o  = rs_data_q;
    assign ex_rt_data_o  = rt_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_rs_o       = rs_q;
    assign ex_rt_o       = rt_q;
    assign ex_rd_o       = rd_q;
    assign ex_valid_o    = valid_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic
// checked against an instruction-level model of the ID/EX stage.
module tb_id_ex_pipe;

    typedef struct {
        logic        regwrite, alusrc, regdst, branch, memread, memwrite, memtoreg;
        logic [2:0]  aluop;
        logic [5:0]  op, funct;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic        valid;
    } stage_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    stage_t id;
    stage_t m;
    logic [15:0] m_sc, m_fc;
    int checks = 0;
    int failures = 0;

    logic        ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg;
    logic [2:0]  ex_aluop;
    logic [5:0]  ex_op, ex_funct;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_valid, stall;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk_i(clk), .rst_i(rst),
        .id_regwrite_i(id.regwrite), .id_alusrc_i(id.alusrc), .id_regdst_i(id.regdst),
        .id_branch_i(id.branch), .id_memread_i(id.memread), .id_memwrite_i(id.memwrite),
        .id_memtoreg_i(id.memtoreg), .id_aluop_i(id.aluop), .id_op_i(id.op),
        .id_funct_i(id.funct), .id_pc4_i(id.pc4), .id_rs_data_i(id.rs_data),
        .id_rt_data_i(id.rt_data), .id_imm_i(id.imm), .id_rs_i(id.rs), .id_rt_i(id.rt),
        .id_rd_i(id.rd), .flush_i(flush),
        .ex_regwrite_o(ex_regwrite), .ex_alusrc_o(ex_alusrc), .ex_regdst_o(ex_regdst),
        .ex_branch_o(ex_branch), .ex_memread_o(ex_memread), .ex_memwrite_o(ex_memwrite),
        .ex_memtoreg_o(ex_memtoreg), .ex_aluop_o(ex_aluop), .ex_op_o(ex_op),
        .ex_funct_o(ex_funct), .ex_pc4_o(ex_pc4), .ex_rs_data_o(ex_rs_data),
        .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
        .ex_rd_o(ex_rd), .ex_valid_o(ex_valid), .stall_o(stall),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Instruction-level decoder: the control word a MIPS decoder emits for each opcode
    function automatic stage_t decode(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
        stage_t s;
        s = '{default: '0};
        s.op = op; s.rs = rs; s.rt = rt; s.rd = rd;
        s.funct = 6'h20;
        s.pc4 = $urandom; s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
        case (op)
            6'd0:  begin s.regwrite = 1'b1; s.regdst = 1'b1; s.aluop = 3'd2; end
            6'd35: begin s.regwrite = 1'b1; s.alusrc = 1'b1; s.memread = 1'b1; s.memtoreg = 1'b1; end
            6'd43: begin s.alusrc = 1'b1; s.memwrite = 1'b1; end
            6'd4, 6'd5: begin s.branch = 1'b1; s.aluop = 3'd1; end
            default: begin s.regwrite = 1'b1; s.alusrc = 1'b1; end
        endcase
        return s;
    endfunction

    function automatic logic model_hz();
        return m.valid && m.memread && (m.rt != 5'd0) && ((m.rt == id.rs) || (m.rt == id.rt));
    endfunction

    function automatic logic [255:0] exp_vec();
        logic [154:0] d;
        d = {m.op, m.funct, m.pc4, m.rs_data, m.rt_data, m.imm, m.rs, m.rt, m.rd};
        if (!m.valid) d = '0;
        return {m.valid, m.regwrite, m.alusrc, m.regdst, m.branch, m.memread, m.memwrite,
                m.memtoreg, m.aluop, d, m_sc, m_fc};
    endfunction

    function automatic logic [255:0] obs_vec();
        logic [154:0] d;
        d = {ex_op, ex_funct, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd};
        if (!m.valid) d = '0;
        return {ex_valid, ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite,
                ex_memtoreg, ex_aluop, d, stall_cnt, flush_cnt};
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_sc = 16'd0;
        m_fc = 16'd0;
    endtask

    // Advance one clock: model decides from pre-edge inputs, DUT sampled 1 ns after the edge
    task automatic step();
        stage_t nxt;
        logic h;
        h = model_hz();
        nxt = id;
        nxt.valid = 1'b1;
        if (flush || h) begin
            nxt.regwrite = 1'b0; nxt.alusrc = 1'b0; nxt.regdst = 1'b0; nxt.branch = 1'b0;
            nxt.memread = 1'b0; nxt.memwrite = 1'b0; nxt.memtoreg = 1'b0; nxt.aluop = 3'd0;
            nxt.valid = 1'b0;
            if (flush) m_fc = (m_fc == 16'hFFFF) ? m_fc : m_fc + 16'd1;
            else       m_sc = (m_sc == 16'hFFFF) ? m_sc : m_sc + 16'd1;
        end
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        id = decode(6'd0, 5'd1, 5'd2, 5'd3);
        model_reset();
        #1;
        checks++;
        if ({obs_vec(), stall} !== '0) begin
            failures++; $display("FAIL reset_initial: got %h expected 0", {obs_vec(), stall});
        end
        #1 rst = 1'b1;
        id = decode(6'd35, 5'd1, 5'd5, 5'd0);
        step();
        id = decode(6'd0, 5'd5, 5'd2, 5'd6);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL reset_prestall: got %b expected 1", stall);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
             ex_aluop, ex_op, ex_funct, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
             ex_rd, ex_valid, stall, stall_cnt, flush_cnt} !== '0) begin
            failures++; $display("FAIL reset_async: outputs nonzero valid=%b stall=%b rt=%0d",
                                 ex_valid, stall, ex_rt);
        end
        model_reset();
        #1 rst = 1'b1;
        id = decode(6'd0, 5'd1, 5'd2, 5'd3);
        step();
        checks++;
        if (ex_regwrite !== 1'b1 || ex_aluop !== 3'd2 || ex_rd !== 5'd3 || ex_valid !== 1'b1) begin
            failures++; $display("FAIL reset_release_add: got rw=%b aluop=%0d rd=%0d valid=%b expected 1 2 3 1",
                                 ex_regwrite, ex_aluop, ex_rd, ex_valid);
        end
    endtask

    task automatic test_load_use();
        id = decode(6'd35, 5'd1, 5'd5, 5'd0);
        step();
        id = decode(6'd0, 5'd5, 5'd2, 5'd6);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL load_use_stall: got %b expected 1", stall);
        end
        step();
        checks++;
        if ({ex_valid, ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite,
             ex_memtoreg, ex_aluop, stall, stall_cnt} !== {11'd0, 1'b0, 16'd1}) begin
            failures++; $display("FAIL load_use_bubble: valid=%b rw=%b mr=%b stall=%b scnt=%0d expected bubble, stall 0, scnt 1",
                                 ex_valid, ex_regwrite, ex_memread, stall, stall_cnt);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs !== 5'd5 || stall_cnt !== 16'd1) begin
            failures++; $display("FAIL load_use_consumer: valid=%b rd=%0d rs=%0d scnt=%0d expected 1 6 5 1",
                                 ex_valid, ex_rd, ex_rs, stall_cnt);
        end
    endtask

    task automatic test_load_zero();
        id = decode(6'd35, 5'd1, 5'd0, 5'd0);
        step();
        id = decode(6'd0, 5'd0, 5'd0, 5'd7);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL load_zero_stall: got %b expected 0", stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL load_zero_nobubble: got valid=%b rd=%0d expected 1 7", ex_valid, ex_rd);
        end
    endtask

    task automatic test_flush_beats_stall();
        async_reset();
        id = decode(6'd35, 5'd1, 5'd5, 5'd0);
        step();
        id = decode(6'd0, 5'd5, 5'd2, 5'd6);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall_out: got %b expected 0", stall);
        end
        step();
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
            flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            failures++; $display("FAIL flush_beats_stall: valid=%b rw=%b fcnt=%0d scnt=%0d expected 0 0 1 0",
                                 ex_valid, ex_regwrite, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_branch();
        id = decode(6'd5, 5'd3, 5'd4, 5'd0);
        step();
        checks++;
        if (ex_op !== 6'd5 || ex_branch !== 1'b1 || ex_aluop !== 3'd1 ||
            ex_regwrite !== 1'b0 || ex_valid !== 1'b1) begin
            failures++; $display("FAIL branch_bne: op=%0d br=%b aluop=%0d rw=%b valid=%b expected 5 1 1 0 1",
                                 ex_op, ex_branch, ex_aluop, ex_regwrite, ex_valid);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [5];
        logic hold;
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd8;
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold)
                id = decode(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            flush = ($urandom_range(0, 9) == 0);
            #1;
            hold = model_hz() && !flush;
            checks++;
            if (stall !== hold) begin
                failures++; $display("FAIL random_stall[%0d]: got %b expected %b", i, stall, hold);
            end
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL random_state[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        async_reset();
        flush = 1'b1;
        repeat (65535) step();
        checks++;
        if (flush_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_reach: got %h expected ffff", flush_cnt);
        end
        step();
        flush = 1'b0;
        checks++;
        if (flush_cnt !== 16'hFFFF || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL sat_hold: got %h expected ffff", flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_zero();
        test_flush_beats_stall();
        test_branch();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
